regfile_writeback_arbiter: RTL

Write-side companion to the 32×32 MIPS register file. It collects register writes from three result sources: load data from memory, ALU results, and jump-and-link return addresses. It buffers them in an in-order queue and drains them one per cycle into the register file's single write port. It also exports a per-register pending scoreboard, so that issue logic can stall reads of registers with writes still in flight.

---
 rtl/regfile_writeback_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/regfile_writeback_arbiter.sv
// regfile_writeback_arbiter
// Collects register-file writes from three result sources (load data, ALU
// results, jump-and-link return addresses), buffers them in an in-order
// circular queue and drains one per cycle into the register file's single
// write port. Also exports a per-register pending scoreboard for issue stalls.
//
// Ports:
//   Clock, Resetn                 rising-edge clock, synchronous active-low reset
//   mem_valid/mem_reg/mem_data    load result request     -> mem_ready
//   alu_valid/alu_reg/alu_data    ALU result request      -> alu_ready
//   link_valid/link_data          link request (to r31)   -> link_ready
//   Hold                          suspends draining
//   WriteReg, WriteData           register file write address / data
//   Reg_write_Control, PC_Store   register file write enable / r31 link enable
//   pending                       per-register write-in-flight mask
//   count                         queue occupancy
module regfile_writeback_arbiter #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    input  logic                     mem_valid,
    input  logic [4:0]               mem_reg,
    input  logic [DATA_W-1:0]        mem_data,
    output logic                     mem_ready,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_reg,
    input  logic [DATA_W-1:0]        alu_data,
    output logic                     alu_ready,
    input  logic                     link_valid,
    input  logic [DATA_W-1:0]        link_data,
    output logic                     link_ready,
    input  logic                     Hold,
    output logic [4:0]               WriteReg,
    output logic [DATA_W-1:0]        WriteData,
    output logic                     Reg_write_Control,
    output logic                     PC_Store,
    output logic [31:0]              pending,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned PW1 = PW + 1;
    localparam int unsigned CW  = PW + 1;

    // Queue storage; link entries are stored with destination r31.
    logic [4:0]        q_rd   [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [DEPTH-1:0]  q_link;
    logic [DEPTH-1:0]  vld;
    logic [DEPTH-1:0]  vld_next;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_next;
    logic [PW-1:0] wr_next;
    logic [PW-1:0] slot_alu;
    logic [PW-1:0] slot_link;

    logic          pop;
    logic [CW-1:0] free;
    logic [CW-1:0] count_next;
    logic          mem_zero;
    logic          alu_zero;
    logic          mem_take;
    logic          alu_take;
    logic          link_take;

    // Pointer wrap for non-power-of-two depths; argument is always < 2*DEPTH.
    function automatic logic [PW-1:0] wrap(input logic [PW1-1:0] x);
        if (x >= PW1'(DEPTH)) begin
            wrap = PW'(x - PW1'(DEPTH));
        end else begin
            wrap = PW'(x);
        end
    endfunction

    // Ready / take arithmetic; r0 requests are discarded and consume no slot.
    always_comb begin
        pop        = (count != '0) && !Hold;
        free       = CW'(DEPTH) - count + CW'(pop);
        mem_zero   = (mem_reg == 5'd0);
        alu_zero   = (alu_reg == 5'd0);
        mem_ready  = mem_zero || (free >= CW'(1));
        mem_take   = mem_valid && mem_ready && !mem_zero;
        alu_ready  = alu_zero || (free >= (CW'(1) + CW'(mem_take)));
        alu_take   = alu_valid && alu_ready && !alu_zero;
        link_ready = (free >= (CW'(1) + CW'(mem_take) + CW'(alu_take)));
        link_take  = link_valid && link_ready;

        slot_alu   = wrap(PW1'(wr_ptr) + PW1'(mem_take));
        slot_link  = wrap(PW1'(wr_ptr) + PW1'(mem_take) + PW1'(alu_take));
        wr_next    = wrap(PW1'(wr_ptr) + PW1'(mem_take) + PW1'(alu_take) + PW1'(link_take));
        rd_next    = wrap(PW1'(rd_ptr) + PW1'(pop));
        count_next = count + CW'(mem_take) + CW'(alu_take) + CW'(link_take) - CW'(pop);
    end

    // Slot valid bits; a slot popped this cycle may be refilled when full.
    always_comb begin
        vld_next = vld;
        if (pop) begin
            vld_next[rd_ptr] = 1'b0;
        end
        if (mem_take) begin
            vld_next[wr_ptr] = 1'b1;
        end
        if (alu_take) begin
            vld_next[slot_alu] = 1'b1;
        end
        if (link_take) begin
            vld_next[slot_link] = 1'b1;
        end
    end

    // Queue payload; contents are qualified by vld so no reset is needed.
    always_ff @(posedge Clock) begin
        if (mem_take) begin
            q_rd[wr_ptr]   <= mem_reg;
            q_data[wr_ptr] <= mem_data;
            q_link[wr_ptr] <= 1'b0;
        end
        if (alu_take) begin
            q_rd[slot_alu]   <= alu_reg;
            q_data[slot_alu] <= alu_data;
            q_link[slot_alu] <= 1'b0;
        end
        if (link_take) begin
            q_rd[slot_link]   <= 5'd31;
            q_data[slot_link] <= link_data;
            q_link[slot_link] <= 1'b1;
        end
    end

    // Pointers, occupancy and registered write-port output stage.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            rd_ptr            <= '0;
            wr_ptr            <= '0;
            count             <= '0;
            vld               <= '0;
            WriteReg          <= 5'd0;
            WriteData         <= '0;
            Reg_write_Control <= 1'b0;
            PC_Store          <= 1'b0;
        end else begin
            rd_ptr <= rd_next;
            wr_ptr <= wr_next;
            count  <= count_next;
            vld    <= vld_next;
            if (pop) begin
                WriteReg          <= q_rd[rd_ptr];
                WriteData         <= q_data[rd_ptr];
                Reg_write_Control <= !q_link[rd_ptr];
                PC_Store          <= q_link[rd_ptr];
            end else begin
                Reg_write_Control <= 1'b0;
                PC_Store          <= 1'b0;
            end
        end
    end

    // Pending mask: queued destinations plus the one currently presented.
    always_comb begin
        pending = 32'd0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (vld[i]) begin
                pending = pending | (32'd1 << q_rd[i]);
            end
        end
        if (Reg_write_Control || PC_Store) begin
            pending = pending | (32'd1 << WriteReg);
        end
        pending[0] = 1'b0;
    end

endmodule
